// File: rtl/lc3b_mem_arbiter.sv
// Shared memory-port arbiter for the LC-3b FE/MEM stages: one transaction at a time, data over fetch.
// Optional fetch starvation guard enabled by defining LC3B_ARB_STARVE_GUARD_EN.
module lc3b_mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        arb_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {FETCH, DATA} owner_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state, state_next;
  owner_t      owner;
  logic [3:0]  cnt;
  logic [14:0] cap_addr;
  logic        cap_we;
  logic        cap_byte;
  logic        cap_lsb;
  logic [15:0] cap_wdata;
  logic        grant_d;
  logic        grant_i;
  logic        force_fetch;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = i_addr[0];

`ifdef LC3B_ARB_STARVE_GUARD_EN
  logic [3:0] starve;

  assign force_fetch = i_req && (starve == 4'(STARVE_LIMIT));

  // Counts data grants that left a waiting fetch behind; any other grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve <= '0;
    end else if (grant_d) begin
      starve <= i_req ? starve + 4'd1 : '0;
    end else if (grant_i) begin
      starve <= '0;
    end
  end
`else
  localparam int unsigned UNUSED_STARVE_LIMIT = STARVE_LIMIT;
  assign force_fetch = 1'b0;
`endif

  assign grant_d = (state == IDLE) && d_req && !force_fetch;
  assign grant_i = (state == IDLE) && i_req && !grant_d;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_d || grant_i) state_next = BUSY;
      BUSY:    if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= FETCH;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_byte  <= 1'b0;
      cap_lsb   <= 1'b0;
      cap_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner     <= DATA;
            cnt       <= CNT_INIT;
            cap_addr  <= d_addr[15:1];
            cap_we    <= d_we;
            cap_byte  <= d_byte;
            cap_lsb   <= d_addr[0];
            // Byte stores replicate the byte onto both lanes; the lane enable picks the half.
            cap_wdata <= d_byte ? {d_wdata[7:0], d_wdata[7:0]} : d_wdata;
          end else if (grant_i) begin
            owner     <= FETCH;
            cnt       <= CNT_INIT;
            cap_addr  <= i_addr[15:1];
            cap_we    <= 1'b0;
            cap_byte  <= 1'b0;
            cap_lsb   <= 1'b0;
            cap_wdata <= '0;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (owner == DATA) d_rdata <= mem_rdata;
            else               i_rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en  = 1'b0;
    mem_we  = '0;
    i_ready = 1'b0;
    d_ready = 1'b0;
    case (state)
      BUSY: begin
        mem_en = 1'b1;
        if ((cnt == 4'd0) && cap_we) begin
          if (!cap_byte)    mem_we = 2'b11;
          else if (cap_lsb) mem_we = 2'b10;
          else              mem_we = 2'b01;
        end
      end
      DONE: begin
        i_ready = (owner == FETCH);
        d_ready = (owner == DATA);
      end
      default: ;
    endcase
  end

  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign arb_busy  = (state != IDLE);

endmodule
